led_bar_dec: RTL

- Parametrised bargraph decoder. Maps a sawtooth counter value into the window [N1, N2) across NUM_LEDS outputs.
- The window is split into NUM_LEDS equal steps of width ceil((N2-N1)/NUM_LEDS).
- One shared iterative divider computes the step size on each window change and the LED index on each sample.
- Supports bar and dot display modes, error and overrun flags. Sits between the N1/N2 threshold registers and the front-panel LED pins.

---
 rtl/led_bar_dec.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/led_bar_dec.sv
// led_bar_dec -- bargraph decoder for the front-panel LED row.
//
// Maps a sampled sawtooth value into the window [N1, N2) across NUM_LEDS
// outputs. The window is divided into NUM_LEDS steps of width
// ceil((N2-N1)/NUM_LEDS). A single restoring divider (one quotient bit per
// clock) is shared between the step computation (on every window change) and
// the LED index computation (on every in-window sample).
//
// Ports:
//   clc_i            clock
//   rst_i            asynchronous active-high reset
//   n1_data_i        window lower bound
//   n2_data_i        window upper bound (exclusive)
//   sawtooth_cntr_i  value to display, taken when sample_i is high
//   sample_i         one-cycle strobe
//   mode_i           0 = bar, 1 = dot; taken together with sample_i
//   led_o            registered LED drive
//   busy_o           divider or output update in progress
//   err_o            current window is invalid (N2 <= N1)
//   ovr_o            one-cycle pulse: a sample_i strobe was dropped
module led_bar_dec #(
    parameter int DATA_W   = 8,
    parameter int NUM_LEDS = 18
) (
    input  logic                clc_i,
    input  logic                rst_i,
    input  logic [DATA_W-1:0]   n1_data_i,
    input  logic [DATA_W-1:0]   n2_data_i,
    input  logic [DATA_W-1:0]   sawtooth_cntr_i,
    input  logic                sample_i,
    input  logic                mode_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                busy_o,
    output logic                err_o,
    output logic                ovr_o
);

    // Divider operand width: (N2-N1)+NUM_LEDS-1 needs one bit more than data.
    localparam int DW    = DATA_W + 1;
    localparam int DIV_N = DW;
    localparam int CW    = $clog2(DIV_N + 1);
    localparam int LW    = $clog2(NUM_LEDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV_SPAN,
        DIV_POS,
        UPDATE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     n1_q, n1_d;
    logic [DATA_W-1:0]     n2_q, n2_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic [DATA_W-1:0]     step_q, step_d;
    logic [DW-1:0]         rem_q, rem_d;
    logic [DW-1:0]         quo_q, quo_d;
    logic [DW-1:0]         dsr_q, dsr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LW-1:0]         lit_q, lit_d;
    logic                  mode_q, mode_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;

    // One restoring-division iteration: shift in the next dividend bit
    // (held in the top of quo_q), subtract the divisor if it fits.
    logic [DW:0]           trial;
    logic                  div_ge;
    logic [DW-1:0]         rem_nxt;
    logic [DW-1:0]         quo_nxt;
    logic                  div_last;
    logic [DW:0]           q_plus1;
    logic [LW-1:0]         lit_div;
    logic [DATA_W-1:0]     step_div;
    logic                  cfg_change;

    assign trial    = {rem_q, quo_q[DW-1]};
    assign div_ge   = (trial >= {1'b0, dsr_q});
    assign rem_nxt  = div_ge ? DW'(trial - {1'b0, dsr_q}) : trial[DW-1:0];
    assign quo_nxt  = {quo_q[DW-2:0], div_ge};
    assign div_last = (cnt_q == CW'(DIV_N - 1));

    // Final quotient is taken straight from the last iteration's result so
    // that no extra cycle is spent after the divider finishes.
    assign q_plus1  = {1'b0, quo_nxt} + (DW+1)'(1);
    assign lit_div  = (q_plus1 >= (DW+1)'(NUM_LEDS)) ? LW'(NUM_LEDS)
                                                     : q_plus1[LW-1:0];
    assign step_div = (quo_nxt == '0) ? DATA_W'(1) : quo_nxt[DATA_W-1:0];

    assign cfg_change = !cfg_valid_q
                     || (n1_data_i != n1_q)
                     || (n2_data_i != n2_q);

    always_comb begin
        state_d     = state_q;
        n1_d        = n1_q;
        n2_d        = n2_q;
        cfg_valid_d = cfg_valid_q;
        step_d      = step_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        lit_d       = lit_q;
        mode_d      = mode_q;
        led_d       = led_q;
        err_d       = err_q;
        ovr_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_change) begin
                    // Window reconfiguration wins over a same-cycle sample.
                    n1_d        = n1_data_i;
                    n2_d        = n2_data_i;
                    cfg_valid_d = 1'b1;
                    ovr_d       = sample_i;
                    if (n2_data_i <= n1_data_i) begin
                        err_d = 1'b1;
                        led_d = '0;
                    end else begin
                        err_d   = 1'b0;
                        rem_d   = '0;
                        quo_d   = DW'({1'b0, n2_data_i} - {1'b0, n1_data_i})
                                + DW'(NUM_LEDS - 1);
                        dsr_d   = DW'(NUM_LEDS);
                        cnt_d   = '0;
                        state_d = DIV_SPAN;
                    end
                end else if (sample_i) begin
                    mode_d = mode_i;
                    if (err_q) begin
                        led_d = '0;
                    end else if (sawtooth_cntr_i < n1_q) begin
                        lit_d   = '0;
                        state_d = UPDATE;
                    end else if (sawtooth_cntr_i >= n2_q) begin
                        lit_d   = LW'(NUM_LEDS);
                        state_d = UPDATE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = {1'b0, sawtooth_cntr_i - n1_q};
                        dsr_d   = {1'b0, step_q};
                        cnt_d   = '0;
                        state_d = DIV_POS;
                    end
                end
            end

            DIV_SPAN: begin
                ovr_d = sample_i;
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + CW'(1);
                if (div_last) begin
                    step_d  = step_div;
                    state_d = IDLE;
                end
            end

            DIV_POS: begin
                ovr_d = sample_i;
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + CW'(1);
                if (div_last) begin
                    lit_d   = lit_div;
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                ovr_d = sample_i;
                for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                    if (mode_q)
                        led_d[i] = ((i + 1) == 32'(lit_q));
                    else
                        led_d[i] = (i < 32'(lit_q));
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clc_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            n1_q        <= '0;
            n2_q        <= '0;
            cfg_valid_q <= 1'b0;
            step_q      <= DATA_W'(1);
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            lit_q       <= '0;
            mode_q      <= 1'b0;
            led_q       <= '0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n1_q        <= n1_d;
            n2_q        <= n2_d;
            cfg_valid_q <= cfg_valid_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            lit_q       <= lit_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = (state_q != IDLE);
    assign err_o  = err_q;
    assign ovr_o  = ovr_q;

endmodule
